// File: rtl/serv_fetch_seq_pkg.sv
// Shared types and constants for the SERV fetch / bit-serial sequencing stage.
package serv_seq_pkg;

    typedef enum logic [2:0] {
        RST    = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        INIT   = 3'd3,
        WAIT   = 3'd4,
        EXEC   = 3'd5
    } seq_state_t;

    localparam logic [4:0] CNT_LAST = 5'd31;

    // Debug view of the sequencer: current state plus the opcode field of the bus word.
    typedef struct packed {
        seq_state_t  state;
        logic [6:0]  opcode;
    } seq_dbg_t;

endpackage

// File: rtl/serv_fetch_seq_if.sv
// Instruction-bus request/ack plus the instruction-latch strobe toward the decoders.
//
// Handshake: o_ibus_cyc is the request and is held until i_ibus_ack. A transfer
// completes in any cycle where both are high, and i_ibus_rdt is valid only then.
// An ack without a request is meaningless. o_wb_en marks that completing cycle
// for the decoders, and o_wb_rdt carries bits [31:7] of the word.
interface serv_fetch_seq_if;
    logic        o_ibus_cyc;
    logic        i_ibus_ack;
    logic [31:0] i_ibus_rdt;
    logic        o_wb_en;
    logic [24:0] o_wb_rdt;

    modport master (
        output o_ibus_cyc,
        output o_wb_en,
        output o_wb_rdt,
        input  i_ibus_ack,
        input  i_ibus_rdt
    );

    modport slave (
        input  o_ibus_cyc,
        input  o_wb_en,
        input  o_wb_rdt,
        output i_ibus_ack,
        output i_ibus_rdt
    );
endinterface

// File: rtl/serv_fetch_seq_bitcnt.sv
// 5-bit bit-serial position counter: enable, synchronous clear, async active-low reset.
module serv_bitcnt
    import serv_seq_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic       i_clr,
    output logic [4:0] o_cnt,
    output logic       o_done
);

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = 5'd0;
        end else if (i_en) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= 5'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt  = cnt_q;
    assign o_done = i_en & (cnt_q == CNT_LAST);

endmodule

// File: rtl/serv_fetch_seq.sv
// Fetch and sequencing FSM: issues the ibus request, strobes the fetched word into
// the decoders, then drives the 32-cycle bit counter (optionally INIT + WAIT first).
module serv_fetch_seq
    import serv_seq_pkg::*;
#(
    parameter bit TWO_STAGE_EN = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    serv_fetch_seq_if.master       bus,
    input  logic                   i_two_stage,
    input  logic                   i_ext_ready,
    output logic                   o_cnt_en,
    output logic [4:0]             o_cnt,
    output logic                   o_cnt_done,
    output logic                   o_init,
    output seq_dbg_t               o_dbg
);

    seq_state_t state_q;
    seq_state_t state_d;

    logic ibus_cyc;
    logic cnt_en;
    logic init;
    logic cnt_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RST:    state_d = FETCH;
            FETCH:  if (bus.i_ibus_ack) state_d = DECODE;
            DECODE: state_d = (i_two_stage && TWO_STAGE_EN) ? INIT : EXEC;
            INIT:   if (cnt_done) state_d = WAIT;
            WAIT:   if (i_ext_ready) state_d = EXEC;
            EXEC:   if (cnt_done) state_d = FETCH;
            default: state_d = RST;
        endcase
    end

    // All control outputs decode registered state only, so they are clean from the edge.
    always_comb begin
        ibus_cyc = 1'b0;
        cnt_en   = 1'b0;
        init     = 1'b0;
        unique case (state_q)
            FETCH: ibus_cyc = 1'b1;
            INIT: begin
                cnt_en = 1'b1;
                init   = 1'b1;
            end
            EXEC:  cnt_en = 1'b1;
            default: ;
        endcase
    end

    // Counter is cleared whenever not shifting, so INIT and EXEC always start at bit 0.
    serv_bitcnt u_bitcnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (cnt_en),
        .i_clr   (~cnt_en),
        .o_cnt   (o_cnt),
        .o_done  (cnt_done)
    );

    assign bus.o_ibus_cyc = ibus_cyc;
    assign bus.o_wb_en    = ibus_cyc & bus.i_ibus_ack;
    assign bus.o_wb_rdt   = bus.i_ibus_rdt[31:7];

    assign o_cnt_en   = cnt_en;
    assign o_cnt_done = cnt_done;
    assign o_init     = init;

    assign o_dbg.state  = state_q;
    assign o_dbg.opcode = bus.i_ibus_rdt[6:0];

endmodule

// File: tb/tb_serv_fetch_seq.sv
// Bench for serv_fetch_seq: random bus/handshake noise against a per-instruction timeline model.
module tb_serv_fetch_seq;
    import serv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ack = 1'b0;
    logic [31:0] rdt = 32'd0;
    logic        two_stage = 1'b0;
    logic        ext_ready = 1'b0;

    always #5 clk = ~clk;

    serv_fetch_seq_if bus_a ();
    serv_fetch_seq_if bus_b ();

    assign bus_a.i_ibus_ack = ack;
    assign bus_a.i_ibus_rdt = rdt;
    assign bus_b.i_ibus_ack = ack;
    assign bus_b.i_ibus_rdt = rdt;

    logic       a_cnt_en, a_cnt_done, a_init;
    logic [4:0] a_cnt;
    seq_dbg_t   a_dbg;
    logic       b_cnt_en, b_cnt_done, b_init;
    logic [4:0] b_cnt;
    seq_dbg_t   b_dbg;

    serv_fetch_seq dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus_a),
        .i_two_stage (two_stage),
        .i_ext_ready (ext_ready),
        .o_cnt_en    (a_cnt_en),
        .o_cnt       (a_cnt),
        .o_cnt_done  (a_cnt_done),
        .o_init      (a_init),
        .o_dbg       (a_dbg)
    );

    serv_fetch_seq #(.TWO_STAGE_EN(1'b0)) dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .bus         (bus_b),
        .i_two_stage (two_stage),
        .i_ext_ready (ext_ready),
        .o_cnt_en    (b_cnt_en),
        .o_cnt       (b_cnt),
        .o_cnt_done  (b_cnt_done),
        .o_init      (b_init),
        .o_dbg       (b_dbg)
    );

    // sel chooses which instance the checks look at.
    logic        sel = 1'b0;
    logic        m_cyc, m_wb, m_en, m_done, m_init;
    logic [4:0]  m_cnt;
    logic [24:0] m_wb_rdt;
    seq_state_t  m_state;

    always_comb begin
        if (sel) begin
            m_cyc = bus_b.o_ibus_cyc; m_wb = bus_b.o_wb_en; m_wb_rdt = bus_b.o_wb_rdt;
            m_en = b_cnt_en; m_cnt = b_cnt; m_done = b_cnt_done; m_init = b_init;
            m_state = b_dbg.state;
        end else begin
            m_cyc = bus_a.o_ibus_cyc; m_wb = bus_a.o_wb_en; m_wb_rdt = bus_a.o_wb_rdt;
            m_en = a_cnt_en; m_cnt = a_cnt; m_done = a_cnt_done; m_init = a_init;
            m_state = a_dbg.state;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cycle(input string ph, input logic cyc, input logic wb, input logic en,
                             input logic [4:0] cnt, input logic done, input logic init);
        chk({ph, ".ibus_cyc"}, 32'(m_cyc), 32'(cyc));
        chk({ph, ".wb_en"},    32'(m_wb), 32'(wb));
        chk({ph, ".cnt_en"},   32'(m_en), 32'(en));
        chk({ph, ".cnt"},      32'(m_cnt), 32'(cnt));
        chk({ph, ".cnt_done"}, 32'(m_done), 32'(done));
        chk({ph, ".init"},     32'(m_init), 32'(init));
    endtask

    task automatic noise();
        ack       = 1'($urandom_range(0, 1));
        two_stage = 1'($urandom_range(0, 1));
        ext_ready = 1'($urandom_range(0, 1));
        rdt       = $urandom;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        noise();
        #1;
        chk_cycle("reset", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("reset.state", 32'(m_state), 32'(RST));
        rst_n = 1'b1;
        #1;
        chk("release.ibus_cyc", 32'(m_cyc), 32'd0);
        chk("release.state", 32'(m_state), 32'(RST));
    endtask

    // One instruction timeline, starting at the cycle where a fetch request is expected.
    task automatic run_instr(input logic [31:0] word, input bit ts, input int ack_delay,
                             input int wait_len, input bit stage_en, input int abort_at);
        for (int d = 0; d <= ack_delay; d++) begin
            @(negedge clk);
            noise();
            ack = (d == ack_delay);
            if (ack) rdt = word;
            #1;
            chk_cycle("fetch", 1'b1, ack, 1'b0, 5'd0, 1'b0, 1'b0);
            if (ack) chk("fetch.wb_rdt", 32'(m_wb_rdt), 32'(word[31:7]));
        end
        @(negedge clk);
        noise();
        two_stage = ts;
        #1;
        chk_cycle("decode", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("decode.state", 32'(m_state), 32'(DECODE));
        if (ts && stage_en) begin
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                noise();
                #1;
                chk_cycle("init", 1'b0, 1'b0, 1'b1, 5'(i), i == 31, 1'b1);
            end
            for (int w = 1; w <= wait_len; w++) begin
                @(negedge clk);
                noise();
                ext_ready = (w == wait_len);
                #1;
                chk_cycle("wait", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
            end
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            noise();
            #1;
            chk_cycle("exec", 1'b0, 1'b0, 1'b1, 5'(i), i == 31, 1'b0);
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk_cycle("abort", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
                chk("abort.state", 32'(m_state), 32'(RST));
                return;
            end
        end
    endtask

    initial begin
        sel = 1'b0;
        do_reset();
        run_instr(32'h00A00093, 1'b0, 2, 1, 1'b1, -1);
        run_instr($urandom, 1'b1, 0, 5, 1'b1, -1);
        run_instr($urandom, 1'b1, 1, 1, 1'b1, -1);
        for (int k = 0; k < 6; k++) begin
            run_instr($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                      $urandom_range(1, 6), 1'b1, -1);
        end
        run_instr($urandom, 1'b0, 0, 1, 1'b1, 17);
        do_reset();
        run_instr($urandom, 1'b1, 0, 2, 1'b1, -1);

        sel = 1'b1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            run_instr($urandom, 1'b1, $urandom_range(0, 2), 1, 1'b0, -1);
        end
        run_instr($urandom, 1'b0, 1, 1, 1'b0, -1);

        @(negedge clk);
        ack = 1'b0;
        #1;
        chk("final.ibus_cyc", 32'(m_cyc), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
